// File: rtl/stoch_pulse_integrator.sv
// Stochastic pulse integrator: counts one-cycle pulses over a 2^WINDOW_BITS window, hands the count out with VALID/ACK.
// Define STOCH_BIPOLAR_EN for bipolar output (2*count - 2^WINDOW_BITS); default build is unipolar.
module stoch_pulse_integrator #(
    parameter int WINDOW_BITS = 8
) (
    input  logic                   clk_i,
    input  logic                   init_i,
    input  logic                   in_i,
    input  logic                   start_i,
    input  logic                   ack_i,
    output logic [WINDOW_BITS+1:0] out_o,
    output logic                   valid_o,
    output logic                   busy_o,
    output logic                   ovr_o,
    output logic [1:0]             state_o
);

    // Handshake: OUT is meaningful while VALID=1; the consumer takes it on the edge where
    // VALID=1 and ACK=1, and VALID drops on that same edge. START outside IDLE/HOLD is ignored.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [WINDOW_BITS+1:0] WIN_SIZE = (WINDOW_BITS+2)'(1) << WINDOW_BITS;

    state_t                 state_q, state_d;
    logic [WINDOW_BITS:0]   acc_q, acc_d;
    logic [WINDOW_BITS-1:0] wcnt_q, wcnt_d;
    logic [WINDOW_BITS+1:0] out_q, out_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   ovr_q, ovr_d;

    logic [WINDOW_BITS:0]   acc_sum;
    logic [WINDOW_BITS+1:0] result;
    logic                   last_sample;

    // The last sample is folded in directly so OUT updates on the same edge it is taken.
    assign acc_sum     = acc_q + {{WINDOW_BITS{1'b0}}, in_i};
    assign last_sample = (wcnt_q == {WINDOW_BITS{1'b1}});

`ifdef STOCH_BIPOLAR_EN
    assign result = {acc_sum, 1'b0} - WIN_SIZE;
`else
    assign result = {1'b0, acc_sum};
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        wcnt_d  = wcnt_q;
        out_d   = out_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_ACCUM;
                    acc_d   = '0;
                    wcnt_d  = '0;
                end
            end
            S_ACCUM: begin
                acc_d  = acc_sum;
                wcnt_d = wcnt_q + WINDOW_BITS'(1);
                if (last_sample) begin
                    out_d   = result;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ack_i) begin
                    valid_d = 1'b0;
                    acc_d   = '0;
                    wcnt_d  = '0;
                    state_d = start_i ? S_ACCUM : S_IDLE;
                end else if (start_i) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_ACCUM);
    end

    always_ff @(posedge clk_i or posedge init_i) begin
        if (init_i) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            wcnt_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            wcnt_q  <= wcnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_o   = out_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign ovr_o   = ovr_q;
    assign state_o = state_q;

endmodule
